pacman_move_ctrl: RTL and testbench



---
 rtl/pacman_pkg.sv | 30 +++
 rtl/pacman_move_ctrl_if.sv | 24 ++
 rtl/dir_req_encoder.sv | 19 +
 rtl/pacman_move_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pacman_move_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared types, defaults and direction helper for the Pac-Man movement block
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BLOCKED = 2'd2
  } move_state_t;

  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_TILE_SIZE = 16;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// rtl/pacman_move_ctrl_if.sv - frame/keyboard/collision inputs and sprite position outputs
interface pacman_move_ctrl_if;
  import pacman_pkg::*;

  logic               startOfFrame;
  logic [3:0]         dirReq;
  logic               collision;
  logic               pause;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  dir_t               curDir;
  logic               moving;

  modport master (
    output startOfFrame, dirReq, collision, pause,
    input  topLeftX, topLeftY, curDir, moving
  );

  modport slave (
    input  startOfFrame, dirReq, collision, pause,
    output topLeftX, topLeftY, curDir, moving
  );

endinterface

// File: rtl/dir_req_encoder.sv
// rtl/dir_req_encoder.sv - priority encoder for {up,down,left,right} keys, up wins
module dir_req_encoder
  import pacman_pkg::*;
(
  input  logic [3:0] dir_req,
  output logic       req_valid,
  output dir_t       req_dir
);

  always_comb begin
    req_valid = |dir_req;
    req_dir   = LEFT;
    if (dir_req[3])      req_dir = UP;
    else if (dir_req[2]) req_dir = DOWN;
    else if (dir_req[1]) req_dir = LEFT;
    else if (dir_req[0]) req_dir = RIGHT;
  end

endmodule

// File: rtl/pacman_move_ctrl.sv
// rtl/pacman_move_ctrl.sv - per-frame sprite movement with grid turns and wall revert
// Optional horizontal tunnel wrap: PACMAN_TUNNEL_WRAP_EN (undefined = clamp at screen edges).
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int INIT_X    = 304,
  parameter int INIT_Y    = 224,
  parameter int STEP      = 2,
  parameter int TILE_SIZE = DEF_TILE_SIZE,
  parameter int OBJ_SIZE  = 16,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H
)(
  input logic               clk,
  input logic               resetN,
  pacman_move_ctrl_if.slave bus
);

  localparam int TILE_BITS = $clog2(TILE_SIZE);
  localparam logic signed [11:0] STEP12 = 12'(STEP);
  localparam logic signed [11:0] ZERO12 = 12'sd0;
  localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - OBJ_SIZE);
`ifdef PACMAN_TUNNEL_WRAP_EN
  localparam logic signed [11:0] X_WRAP_LO = 12'(-OBJ_SIZE);
  localparam logic signed [11:0] X_WRAP_HI = 12'(SCREEN_W - 1);
`else
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - OBJ_SIZE);
`endif

  move_state_t        state_q, state_d;
  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic signed [10:0] px_q, px_d, py_q, py_d;
  dir_t               dir_q, dir_d;
  dir_t               pend_q;
  logic               latch_q;

  logic               req_valid;
  dir_t               req_dir;
  logic               aligned;
  logic               frame_hit;
  logic signed [11:0] x12, y12;
  logic signed [11:0] nx, ny;
  logic               do_step, hit, wrapped;
  dir_t               step_dir;

  dir_req_encoder u_enc (
    .dir_req   (bus.dirReq),
    .req_valid (req_valid),
    .req_dir   (req_dir)
  );

  assign aligned   = (x_q[TILE_BITS-1:0] == '0) && (y_q[TILE_BITS-1:0] == '0);
  // A collision landing on the frame pulse still belongs to the frame just scanned.
  assign frame_hit = latch_q | bus.collision;
  assign x12       = {x_q[10], x_q};
  assign y12       = {y_q[10], y_q};

  always_ff @(posedge clk) begin
    if (!resetN) begin
      pend_q <= LEFT;
    end else if (req_valid) begin
      pend_q <= req_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN)               latch_q <= 1'b0;
    else if (bus.startOfFrame) latch_q <= 1'b0;
    else if (bus.collision)    latch_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      x_q     <= 11'(INIT_X);
      y_q     <= 11'(INIT_Y);
      px_q    <= 11'(INIT_X);
      py_q    <= 11'(INIT_Y);
      dir_q   <= LEFT;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    px_d     = px_q;
    py_d     = py_q;
    dir_d    = dir_q;
    step_dir = dir_q;
    do_step  = 1'b0;
    hit      = 1'b0;
    wrapped  = 1'b0;
    nx       = x12;
    ny       = y12;

    if (bus.startOfFrame) begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (bus.pause) begin
            state_d = RUN;
          end else if (frame_hit) begin
            x_d     = px_q;
            y_d     = py_q;
            state_d = BLOCKED;
          end else begin
            // Reversal is allowed anywhere; perpendicular turns only on the tile grid.
            if ((pend_q == opposite(dir_q)) || ((pend_q != dir_q) && aligned))
              step_dir = pend_q;
            do_step = 1'b1;
          end
        end
        BLOCKED: begin
          if ((pend_q != dir_q) && !bus.pause) begin
            step_dir = pend_q;
            do_step  = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_step) begin
      case (step_dir)
        UP: begin
          ny = y12 - STEP12;
          if (ny <= ZERO12) begin ny = ZERO12; hit = 1'b1; end
        end
        DOWN: begin
          ny = y12 + STEP12;
          if (ny >= Y_MAX) begin ny = Y_MAX; hit = 1'b1; end
        end
        LEFT: begin
          nx = x12 - STEP12;
`ifdef PACMAN_TUNNEL_WRAP_EN
          if (nx < X_WRAP_LO) begin nx = X_WRAP_HI; wrapped = 1'b1; end
`else
          if (nx <= ZERO12) begin nx = ZERO12; hit = 1'b1; end
`endif
        end
        default: begin
          nx = x12 + STEP12;
`ifdef PACMAN_TUNNEL_WRAP_EN
          if (nx > X_WRAP_HI) begin nx = X_WRAP_LO; wrapped = 1'b1; end
`else
          if (nx >= X_MAX) begin nx = X_MAX; hit = 1'b1; end
`endif
        end
      endcase
      dir_d = step_dir;
      x_d   = nx[10:0];
      y_d   = ny[10:0];
      // After a wrap a later revert must not jump back across the screen.
      px_d  = wrapped ? nx[10:0] : x_q;
      py_d  = y_q;
      if (hit) state_d = BLOCKED;
    end
  end

  assign bus.topLeftX = x_q;
  assign bus.topLeftY = y_q;
  assign bus.curDir   = dir_q;
  assign bus.moving   = (state_q == RUN);

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// tb/tb_pacman_move_ctrl.sv - directed self-checking bench for pacman_move_ctrl
module tb_pacman_move_ctrl;
  import pacman_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  int   checks = 0;
  int   errors = 0;

  pacman_move_ctrl_if bus();

  pacman_move_ctrl dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    resetN           = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.dirReq       = 4'b0000;
    bus.collision    = 1'b0;
    bus.pause        = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame(input logic col);
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    bus.collision    = col;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.collision    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] keys);
    @(negedge clk);
    bus.dirReq = keys;
    @(negedge clk);
    bus.dirReq = 4'b0000;
  endtask

  task automatic pulse_collision();
    @(negedge clk);
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (int'(bus.topLeftX) !== 304) begin errors++; $display("FAIL reset_x got %0d want 304", bus.topLeftX); end
    checks++; if (int'(bus.topLeftY) !== 224) begin errors++; $display("FAIL reset_y got %0d want 224", bus.topLeftY); end
    checks++; if (bus.curDir !== LEFT) begin errors++; $display("FAIL reset_dir got %0d want %0d", bus.curDir, LEFT); end
    checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %0b want 0", bus.moving); end
    frame(1'b0); frame(1'b0); frame(1'b0);
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    checks++; if (int'(bus.topLeftX) !== 304) begin errors++; $display("FAIL midreset_x got %0d want 304", bus.topLeftX); end
    checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL midreset_moving got %0b want 0", bus.moving); end
    resetN = 1'b1;
  endtask

  task automatic test_run_left();
    do_reset();
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 304) begin errors++; $display("FAIL run_f1_x got %0d want 304", bus.topLeftX); end
    checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL run_f1_moving got %0b want 1", bus.moving); end
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 302) begin errors++; $display("FAIL run_f2_x got %0d want 302", bus.topLeftX); end
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 300) begin errors++; $display("FAIL run_f3_x got %0d want 300", bus.topLeftX); end
    checks++; if (int'(bus.topLeftY) !== 224) begin errors++; $display("FAIL run_f3_y got %0d want 224", bus.topLeftY); end
    checks++; if (bus.curDir !== LEFT) begin errors++; $display("FAIL run_f3_dir got %0d want %0d", bus.curDir, LEFT); end
  endtask

  task automatic test_pre_turn();
    do_reset();
    frame(1'b0); frame(1'b0); frame(1'b0);
    press(4'b1000);
    for (int ex = 298; ex >= 288; ex -= 2) begin
      frame(1'b0);
      checks++; if (int'(bus.topLeftX) !== ex || bus.curDir !== LEFT) begin
        errors++; $display("FAIL preturn_wait got x=%0d dir=%0d want x=%0d dir=%0d", bus.topLeftX, bus.curDir, ex, LEFT);
      end
    end
    frame(1'b0);
    checks++; if (bus.curDir !== UP) begin errors++; $display("FAIL preturn_dir got %0d want %0d", bus.curDir, UP); end
    checks++; if (int'(bus.topLeftX) !== 288 || int'(bus.topLeftY) !== 222) begin
      errors++; $display("FAIL preturn_pos got (%0d,%0d) want (288,222)", bus.topLeftX, bus.topLeftY);
    end
  endtask

  task automatic test_reverse();
    do_reset();
    frame(1'b0); frame(1'b0); frame(1'b0);
    press(4'b0001);
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 302 || bus.curDir !== RIGHT) begin
      errors++; $display("FAIL reverse got x=%0d dir=%0d want x=302 dir=%0d", bus.topLeftX, bus.curDir, RIGHT);
    end
    press(4'b0111);
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 304 || bus.curDir !== RIGHT) begin
      errors++; $display("FAIL prio_wait got x=%0d dir=%0d want x=304 dir=%0d", bus.topLeftX, bus.curDir, RIGHT);
    end
    frame(1'b0);
    checks++; if (int'(bus.topLeftY) !== 226 || int'(bus.topLeftX) !== 304 || bus.curDir !== DOWN) begin
      errors++; $display("FAIL prio_turn got (%0d,%0d) dir=%0d want (304,226) dir=%0d", bus.topLeftX, bus.topLeftY, bus.curDir, DOWN);
    end
  endtask

  task automatic test_collision();
    do_reset();
    repeat (10) frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 286) begin errors++; $display("FAIL col_pre_x got %0d want 286", bus.topLeftX); end
    pulse_collision();
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 288 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL col_revert got x=%0d moving=%0b want x=288 moving=0", bus.topLeftX, bus.moving);
    end
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 288 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL col_stay got x=%0d moving=%0b want x=288 moving=0", bus.topLeftX, bus.moving);
    end
    press(4'b0100);
    frame(1'b0);
    checks++; if (int'(bus.topLeftY) !== 226 || int'(bus.topLeftX) !== 288 || bus.moving !== 1'b1 || bus.curDir !== DOWN) begin
      errors++; $display("FAIL col_unblock got (%0d,%0d) moving=%0b dir=%0d want (288,226) moving=1 dir=%0d",
                         bus.topLeftX, bus.topLeftY, bus.moving, bus.curDir, DOWN);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    frame(1'b0); frame(1'b0); frame(1'b0);
    frame(1'b1);
    checks++; if (int'(bus.topLeftX) !== 302 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL coin_revert got x=%0d moving=%0b want x=302 moving=0", bus.topLeftX, bus.moving);
    end
    press(4'b1000);
    frame(1'b0);
    checks++; if (int'(bus.topLeftY) !== 222 || int'(bus.topLeftX) !== 302 || bus.moving !== 1'b1) begin
      errors++; $display("FAIL coin_turn got (%0d,%0d) moving=%0b want (302,222) moving=1", bus.topLeftX, bus.topLeftY, bus.moving);
    end
    frame(1'b0);
    checks++; if (int'(bus.topLeftY) !== 220) begin errors++; $display("FAIL coin_step got %0d want 220", bus.topLeftY); end
    bus.pause = 1'b1;
    frame(1'b1);
    checks++; if (int'(bus.topLeftY) !== 220 || bus.moving !== 1'b1) begin
      errors++; $display("FAIL pause_hold got y=%0d moving=%0b want y=220 moving=1", bus.topLeftY, bus.moving);
    end
    bus.pause = 1'b0;
    frame(1'b0);
    checks++; if (int'(bus.topLeftY) !== 218 || bus.moving !== 1'b1) begin
      errors++; $display("FAIL pause_nocarry got y=%0d moving=%0b want y=218 moving=1", bus.topLeftY, bus.moving);
    end
  endtask

  task automatic test_bounds_x();
    do_reset();
`ifdef PACMAN_TUNNEL_WRAP_EN
    repeat (161) frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== -16 || bus.moving !== 1'b1) begin
      errors++; $display("FAIL wrap_edge got x=%0d moving=%0b want x=-16 moving=1", bus.topLeftX, bus.moving);
    end
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 639 || bus.moving !== 1'b1) begin
      errors++; $display("FAIL wrap_jump got x=%0d moving=%0b want x=639 moving=1", bus.topLeftX, bus.moving);
    end
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 637) begin errors++; $display("FAIL wrap_after got %0d want 637", bus.topLeftX); end
`else
    repeat (153) frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 0 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL clampx_edge got x=%0d moving=%0b want x=0 moving=0", bus.topLeftX, bus.moving);
    end
    frame(1'b0);
    checks++; if (int'(bus.topLeftX) !== 0 || bus.moving !== 1'b0 || bus.curDir !== LEFT) begin
      errors++; $display("FAIL clampx_hold got x=%0d moving=%0b dir=%0d want x=0 moving=0 dir=%0d", bus.topLeftX, bus.moving, bus.curDir, LEFT);
    end
`endif
  endtask

  task automatic test_bounds_y();
    do_reset();
    press(4'b1000);
    frame(1'b0);
    checks++; if (bus.curDir !== LEFT || int'(bus.topLeftY) !== 224) begin
      errors++; $display("FAIL idle_nomove got y=%0d dir=%0d want y=224 dir=%0d", bus.topLeftY, bus.curDir, LEFT);
    end
    frame(1'b0);
    checks++; if (bus.curDir !== UP || int'(bus.topLeftY) !== 222) begin
      errors++; $display("FAIL clampy_turn got y=%0d dir=%0d want y=222 dir=%0d", bus.topLeftY, bus.curDir, UP);
    end
    repeat (111) frame(1'b0);
    checks++; if (int'(bus.topLeftY) !== 0 || bus.moving !== 1'b0 || int'(bus.topLeftX) !== 304) begin
      errors++; $display("FAIL clampy_edge got (%0d,%0d) moving=%0b want (304,0) moving=0", bus.topLeftX, bus.topLeftY, bus.moving);
    end
    frame(1'b0);
    checks++; if (int'(bus.topLeftY) !== 0) begin errors++; $display("FAIL clampy_hold got %0d want 0", bus.topLeftY); end
  endtask

  initial begin
    test_reset();
    test_run_left();
    test_pre_turn();
    test_reverse();
    test_collision();
    test_coincident();
    test_bounds_x();
    test_bounds_y();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
